// File: rtl/esn_pkg.sv
// rtl/esn_pkg.sv - shared types and defaults for the ESN phase sequencer
// Contents: FSM state enum, default N_RES / ADDR_W / MAC_LAT, and the
// delay-line payload that tracks each issued operand until its MAC result lands.
package esn_pkg;

    localparam int N_RES_DEF   = 8;
    localparam int ADDR_W_DEF  = 3;
    localparam int MAC_LAT_DEF = 2;

    // Row field width of the delay payload; ADDR_W must not exceed it.
    localparam int DLY_ROW_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RES      = 3'd1,
        S_RES_WAIT = 3'd2,
        S_SWAP     = 3'd3,
        S_RDO      = 3'd4,
        S_RDO_WAIT = 3'd5
    } state_t;

    typedef struct packed {
        logic                 last;
        logic                 mode;
        logic [DLY_ROW_W-1:0] row;
    } dly_t;

endpackage

// File: rtl/esn_sched_dly.sv
// rtl/esn_sched_dly.sv - MAC_LAT-stage shift register of delay-line payloads
// Ports: clk, rst_n (async active-low clear), din (payload at issue),
//        dout (payload MAC_LAT cycles later, aligned with the MAC result).
module esn_sched_dly
    import esn_pkg::*;
#(
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  dly_t din,
    output dly_t dout
);

    dly_t stage_q [MAC_LAT];
    dly_t stage_d [MAC_LAT];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < MAC_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAC_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[MAC_LAT-1];

endmodule

// File: rtl/esn_sched.sv
// rtl/esn_sched.sv - ESN phase sequencer sharing one MAC between reservoir update and readout
// Ports: clk, rst_N (async active-low); ce (readout enable, sampled in SWAP);
//        in_valid/in_ready sample handshake; mac_en/mac_clr/mode/row_idx/col_idx/use_in
//        operand issue; st_we/st_waddr next-state write; swap buffer pulse;
//        est_valid readout pulse; busy = ~in_ready.
module esn_sched
    import esn_pkg::*;
#(
    parameter int N_RES   = N_RES_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_N,
    input  logic              ce,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              mode,
    output logic [ADDR_W-1:0] row_idx,
    output logic [ADDR_W-1:0] col_idx,
    output logic              use_in,
    output logic              st_we,
    output logic [ADDR_W-1:0] st_waddr,
    output logic              swap,
    output logic              est_valid,
    output logic              busy
);

    // One extra bit so the column counter can reach N_RES (the input-weight tap).
    localparam int CNT_W = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic              issue_last;
    logic              res_done;
    dly_t              dly_in;
    dly_t              dly_out;

    esn_sched_dly #(
        .MAC_LAT (MAC_LAT)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_N),
        .din   (dly_in),
        .dout  (dly_out)
    );

    always_comb begin
        dly_in      = '0;
        dly_in.last = issue_last;
        dly_in.mode = mode;
        dly_in.row  = DLY_ROW_W'(row_idx);
    end

    assign st_we     = dly_out.last & ~dly_out.mode;
    assign st_waddr  = st_we ? dly_out.row[ADDR_W-1:0] : '0;
    assign est_valid = dly_out.last & dly_out.mode;
    // Only the last row's write ends the reservoir phase, even for long MAC latencies.
    assign res_done  = st_we && (dly_out.row == DLY_ROW_W'(N_RES - 1));
    assign busy      = ~in_ready;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        in_ready   = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        mode       = 1'b0;
        row_idx    = '0;
        col_idx    = '0;
        use_in     = 1'b0;
        swap       = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_RES;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RES: begin
                mac_en  = 1'b1;
                row_idx = row_q;
                mac_clr = (col_q == '0);
                if (col_q == CNT_W'(N_RES)) begin
                    use_in     = 1'b1;
                    issue_last = 1'b1;
                    col_d      = '0;
                    if (row_q == ADDR_W'(N_RES - 1)) begin
                        state_d = S_RES_WAIT;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ADDR_W'(1);
                    end
                end else begin
                    col_idx = col_q[ADDR_W-1:0];
                    col_d   = col_q + CNT_W'(1);
                end
            end
            S_RES_WAIT: begin
                if (res_done) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                swap    = 1'b1;
                state_d = ce ? S_RDO : S_IDLE;
            end
            S_RDO: begin
                mac_en  = 1'b1;
                mode    = 1'b1;
                col_idx = col_q[ADDR_W-1:0];
                mac_clr = (col_q == '0);
                if (col_q == CNT_W'(N_RES - 1)) begin
                    issue_last = 1'b1;
                    col_d      = '0;
                    state_d    = S_RDO_WAIT;
                end else begin
                    col_d = col_q + CNT_W'(1);
                end
            end
            S_RDO_WAIT: begin
                if (est_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

endmodule
